// File: rtl/if_stage_scoreboard_if.sv
// if_stage_scoreboard_if: loader, redirect, decode handshake, writeback and fetch outputs.
// Latency: none, wiring only.
// Backpressure: id_ready from decode; stall/if_valid report the fetch register state.
interface if_stage_scoreboard_if #(
  parameter int SIZE       = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 32
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  // instruction memory loader
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [SIZE-1:0] imem_wdata;

  // control flow and pipeline feedback
  logic            redirect_valid;
  logic [SIZE-1:0] redirect_pc;
  logic            id_ready;
  logic            wb_valid;
  logic [RW-1:0]   wb_reg;

  // fetch register view
  logic             if_valid;
  logic [SIZE-1:0]  Instruction;
  logic [SIZE-1:0]  PC_4;
  logic             stall;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output imem_we, imem_waddr, imem_wdata,
    output redirect_valid, redirect_pc, id_ready, wb_valid, wb_reg,
    input  if_valid, Instruction, PC_4, stall, stall_count
  );

  modport slave (
    input  imem_we, imem_waddr, imem_wdata,
    input  redirect_valid, redirect_pc, id_ready, wb_valid, wb_reg,
    output if_valid, Instruction, PC_4, stall, stall_count
  );
endinterface

// File: rtl/if_stage_scoreboard.sv
// if_stage_scoreboard: MIPS fetch stage with a per-register RAW scoreboard and branch redirect.
// Latency: fetch register refills 1 cycle after reset/redirect; 1 instruction per cycle when unstalled.
// Backpressure: holds the fetch register while id_ready is low or a source register is pending.
module if_stage_scoreboard #(
  parameter int SIZE       = 32,
  parameter int IMEM_DEPTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_W      = 32
) (
  input logic clk,
  input logic rst,
  if_stage_scoreboard_if.slave bus
);
  localparam int AW = $clog2(IMEM_DEPTH);
  localparam int RW = $clog2(NUM_REGS);

  // opcodes that write a register
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;

  // MIPS instruction fields
  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } instr_hdr_t;

  logic [SIZE-1:0]     imem [IMEM_DEPTH];

  logic [SIZE-1:0]     pc_q;
  logic                if_valid_q;
  logic [SIZE-1:0]     instr_q;
  logic [SIZE-1:0]     pc4_q;
  logic [NUM_REGS-1:0] pending_q;
  logic [CNT_W-1:0]    stall_cnt_q;

  instr_hdr_t          hdr;
  logic [SIZE-1:0]     fetch_word;
  logic [SIZE-1:0]     pc_next;
  logic [RW-1:0]       rs_idx;
  logic [RW-1:0]       rt_idx;
  logic                has_dest;
  logic [RW-1:0]       dest_idx;
  logic                stall;
  logic                handoff;
  logic                load;
  logic [NUM_REGS-1:0] pend_d;

  assign hdr        = instr_hdr_t'(instr_q[31:0]);
  assign fetch_word = imem[pc_q[AW+1:2]];
  assign pc_next    = pc_q + SIZE'(4);
  assign rs_idx     = hdr.rs[RW-1:0];
  assign rt_idx     = hdr.rt[RW-1:0];

  // Loader port; a fetch from the same word this cycle still sees the old contents.
  always_ff @(posedge clk) begin
    if (bus.imem_we) begin
      imem[bus.imem_waddr] <= bus.imem_wdata;
    end
  end

  // Destination decode of the instruction sitting in the fetch register.
  always_comb begin
    has_dest = 1'b0;
    dest_idx = '0;
    case (hdr.opcode)
      OP_RTYPE: begin
        has_dest = 1'b1;
        dest_idx = hdr.rd[RW-1:0];
      end
      OP_ADDI, OP_ANDI, OP_ORI, OP_LW: begin
        has_dest = 1'b1;
        dest_idx = hdr.rt[RW-1:0];
      end
      default: begin
        has_dest = 1'b0;
        dest_idx = '0;
      end
    endcase
  end

  // Both source fields are always checked; a same-cycle writeback does not unblock.
  assign stall   = if_valid_q & (pending_q[rs_idx] | pending_q[rt_idx]);
  assign handoff = if_valid_q & bus.id_ready & ~stall & ~bus.redirect_valid;
  assign load    = ~bus.redirect_valid & (~if_valid_q | handoff);

  // Scoreboard update: writeback clears first, so a same-cycle handoff set wins.
  always_comb begin
    pend_d = pending_q;
    if (bus.wb_valid) begin
      pend_d[bus.wb_reg] = 1'b0;
    end
    if (handoff && has_dest && (dest_idx != '0)) begin
      pend_d[dest_idx] = 1'b1;
    end
  end

  // Scoreboard register; r0 is never set because the set path excludes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pend_d;
    end
  end

  // PC and fetch register: redirect flushes, otherwise refill when empty or handed off.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= '0;
      if_valid_q <= 1'b0;
      instr_q    <= '0;
      pc4_q      <= '0;
    end else if (bus.redirect_valid) begin
      pc_q       <= {bus.redirect_pc[SIZE-1:2], 2'b00};
      if_valid_q <= 1'b0;
    end else if (load) begin
      pc_q       <= pc_next;
      if_valid_q <= 1'b1;
      instr_q    <= fetch_word;
      pc4_q      <= pc_next;
    end
  end

  // Saturating count of cycles spent stalled on a RAW hazard.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  // Invariants: r0 is never tracked and a stall always refers to a held instruction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!pending_q[0]);
      assert (!stall || if_valid_q);
    end
  end

  assign bus.if_valid    = if_valid_q;
  assign bus.Instruction = instr_q;
  assign bus.PC_4        = pc4_q;
  assign bus.stall       = stall;
  assign bus.stall_count = stall_cnt_q;

  // Fields not needed for hazard tracking.
  logic unused_bits;
  assign unused_bits = ^{bus.redirect_pc[1:0], hdr.shamt, hdr.funct};
endmodule

// File: tb/tb_if_stage_scoreboard.sv
// tb_if_stage_scoreboard: directed vector table, hand sequences and a randomized model check.
// Latency: checks outputs 1 time unit after each rising edge.
// Backpressure: drives id_ready/wb directly; no flow control of its own.
module tb_if_stage_scoreboard;
  localparam int SIZE  = 32;
  localparam int DEPTH = 32;
  localparam int NREGS = 32;
  localparam int CW    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_stage_scoreboard_if #(.SIZE(SIZE), .IMEM_DEPTH(DEPTH), .NUM_REGS(NREGS), .CNT_W(CW)) bus ();

  if_stage_scoreboard #(.SIZE(SIZE), .IMEM_DEPTH(DEPTH), .NUM_REGS(NREGS), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          sc;
    bit          idr;
    bit          wbv;
    int          wbr;
    bit          rv;
    logic [31:0] rpc;
    bit          ev;
    logic [31:0] epc4;
    logic [31:0] einstr;
    bit          est;
    int          ecnt;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] img[DEPTH];

  // Reference model: architectural view of the fetch stage.
  bit          m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;
  bit          m_pend[int];
  int          m_cnt;
  logic [31:0] m_mem[DEPTH];

  function automatic logic [31:0] add_i(int rd, int rs, int rt);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
  endfunction

  function automatic int dest_of(logic [31:0] w);
    case (int'(w[31:26]))
      0:              return int'(w[15:11]);
      8, 12, 13, 35:  return int'(w[20:16]);
      default:        return -1;
    endcase
  endfunction

  function automatic bit model_stall();
    return m_valid && (m_pend.exists(int'(m_instr[25:21])) || m_pend.exists(int'(m_instr[20:16])));
  endfunction

  task automatic model_step(input bit r, input bit we, input int waddr, input logic [31:0] wdata,
                            input bit idr, input bit wbv, input int wbr, input bit rv, input logic [31:0] rpc);
    logic [31:0] word;
    bit hz;
    int dst;
    word = m_mem[(m_pc >> 2) % DEPTH];
    if (r) begin
      m_valid = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_cnt = 0;
      m_pend.delete();
    end else begin
      hz = model_stall();
      if (hz && m_cnt < (1 << CW) - 1) m_cnt++;
      if (wbv && m_pend.exists(wbr)) m_pend.delete(wbr);
      if (rv) begin
        m_valid = 0;
        m_pc = rpc & ~32'd3;
      end else if (!m_valid || (idr && !hz)) begin
        if (m_valid) begin
          dst = dest_of(m_instr);
          if (dst > 0) m_pend[dst] = 1;
        end
        m_instr = word;
        m_pc4   = m_pc + 32'd4;
        m_pc    = m_pc + 32'd4;
        m_valid = 1;
      end
    end
    if (we) m_mem[waddr] = wdata;
  endtask

  task automatic tick(input bit r, input bit we, input int waddr, input logic [31:0] wdata,
                      input bit idr, input bit wbv, input int wbr, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    rst                = r;
    bus.imem_we        = we;
    bus.imem_waddr     = 5'(waddr);
    bus.imem_wdata     = wdata;
    bus.id_ready       = idr;
    bus.wb_valid       = wbv;
    bus.wb_reg         = 5'(wbr);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    @(posedge clk);
    model_step(r, we, waddr, wdata, idr, wbv, wbr, rv, rpc);
    #1;
  endtask

  task automatic step(input bit idr, input bit wbv, input int wbr);
    tick(1'b0, 1'b0, 0, 32'd0, idr, wbv, wbr, 1'b0, 32'd0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input bit ev, input logic [31:0] epc4, input logic [31:0] einstr,
                         input bit est, input int ecnt);
    chk($sformatf("%s.valid", tag), 32'(bus.if_valid), 32'(ev));
    chk($sformatf("%s.pc4", tag),   bus.PC_4, epc4);
    chk($sformatf("%s.instr", tag), bus.Instruction, einstr);
    chk($sformatf("%s.stall", tag), 32'(bus.stall), 32'(est));
    chk($sformatf("%s.cnt", tag),   32'(bus.stall_count), 32'(ecnt));
  endtask

  task automatic chk_model(input string tag);
    chk_out(tag, m_valid, m_pc4, m_instr, model_stall(), m_cnt);
  endtask

  // Hold reset while loading the whole image, then check the reset state.
  task automatic reset_load();
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 1'b1, i, img[i], 1'b0, 1'b0, 0, 1'b0, 32'd0);
    chk_out("reset", 1'b0, 32'd0, 32'd0, 1'b0, 0);
  endtask

  function automatic vec_t mk(int sc, bit idr, bit wbv, int wbr, bit rv, logic [31:0] rpc,
                              bit ev, logic [31:0] epc4, logic [31:0] einstr, bit est, int ecnt);
    vec_t v;
    v.sc = sc; v.idr = idr; v.wbv = wbv; v.wbr = wbr; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.epc4 = epc4; v.einstr = einstr; v.est = est; v.ecnt = ecnt;
    return v;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [5:0] op;
    case ($urandom_range(0, 6))
      0, 1:    op = 6'h00;
      2:       op = 6'h08;
      3:       op = 6'h0C;
      4:       op = 6'h0D;
      5:       op = 6'h23;
      default: op = 6'h04;
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 11'($urandom)};
  endfunction

  task automatic setup_img(input int sc);
    for (int i = 0; i < DEPTH; i++) img[i] = 32'd0;
    case (sc)
      1: begin img[0] = add_i(1, 2, 3); img[1] = add_i(4, 5, 6); img[2] = add_i(7, 8, 9); end
      2: begin img[0] = add_i(1, 2, 3); img[1] = add_i(4, 1, 0); end
      3: begin img[0] = add_i(0, 2, 3); img[1] = add_i(4, 0, 0); end
      4: begin img[0] = add_i(1, 2, 3); img[1] = add_i(4, 1, 0);
               img[4] = add_i(10, 11, 12); img[5] = add_i(13, 1, 0); end
      5: begin img[0] = add_i(5, 2, 3); img[1] = add_i(6, 5, 0); end
      default: ;
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0, a1, a2, b0, b1, c0, c1, d4, d5, e0, e1, w31, w0, wd, rpc;
    int prev, wa, wbr;
    bit r, we, idr, wbv, rv;

    a0 = add_i(1, 2, 3);  a1 = add_i(4, 5, 6);  a2 = add_i(7, 8, 9);
    b0 = add_i(1, 2, 3);  b1 = add_i(4, 1, 0);
    c0 = add_i(0, 2, 3);  c1 = add_i(4, 0, 0);
    d4 = add_i(10, 11, 12); d5 = add_i(13, 1, 0);
    e0 = add_i(5, 2, 3);  e1 = add_i(6, 5, 0);

    // 1: independent R-types stream back to back
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'd4,  a0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'd8,  a1, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'd12, a2, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 0, 1, 32'd16, 0,  0, 0));
    // 2: RAW on r1, writeback on the third stalled cycle
    vecs.push_back(mk(2, 1, 0, 0, 0, 0, 1, 32'd4,  b0, 0, 0));
    vecs.push_back(mk(2, 1, 0, 0, 0, 0, 1, 32'd8,  b1, 1, 0));
    vecs.push_back(mk(2, 1, 0, 0, 0, 0, 1, 32'd8,  b1, 1, 1));
    vecs.push_back(mk(2, 1, 0, 0, 0, 0, 1, 32'd8,  b1, 1, 2));
    vecs.push_back(mk(2, 1, 1, 1, 0, 0, 1, 32'd8,  b1, 0, 3));
    vecs.push_back(mk(2, 1, 0, 0, 0, 0, 1, 32'd12, 0,  0, 3));
    // 3: r0 is never a hazard
    vecs.push_back(mk(3, 1, 0, 0, 0, 0, 1, 32'd4,  c0, 0, 0));
    vecs.push_back(mk(3, 1, 0, 0, 0, 0, 1, 32'd8,  c1, 0, 0));
    vecs.push_back(mk(3, 1, 0, 0, 0, 0, 1, 32'd12, 0,  0, 0));
    // 4: redirect to 0x11 while stalled; r1 stays pending until writeback
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'd4,    b0, 0, 0));
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'd8,    b1, 1, 0));
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'd8,    b1, 1, 1));
    vecs.push_back(mk(4, 1, 0, 0, 1, 32'h11,   0, 32'd8,    b1, 0, 2));
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'h14,   d4, 0, 2));
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'h18,   d5, 1, 2));
    vecs.push_back(mk(4, 1, 1, 1, 0, 0,        1, 32'h18,   d5, 0, 3));
    vecs.push_back(mk(4, 1, 0, 0, 0, 0,        1, 32'h1C,   0,  0, 3));
    // 5: handoff of an r5 writer with a same-cycle writeback of r5
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 1, 32'd4,  e0, 0, 0));
    vecs.push_back(mk(5, 1, 1, 5, 0, 0, 1, 32'd8,  e1, 1, 0));
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 1, 32'd8,  e1, 1, 1));
    vecs.push_back(mk(5, 1, 1, 5, 0, 0, 1, 32'd8,  e1, 0, 2));
    vecs.push_back(mk(5, 1, 0, 0, 0, 0, 1, 32'd12, 0,  0, 2));

    prev = -1;
    foreach (vecs[i]) begin
      if (vecs[i].sc != prev) begin
        setup_img(vecs[i].sc);
        reset_load();
        prev = vecs[i].sc;
      end
      tick(1'b0, 1'b0, 0, 32'd0, vecs[i].idr, vecs[i].wbv, vecs[i].wbr, vecs[i].rv, vecs[i].rpc);
      chk_out($sformatf("vec%0d_sc%0d", i, vecs[i].sc), vecs[i].ev, vecs[i].epc4, vecs[i].einstr,
              vecs[i].est, vecs[i].ecnt);
    end

    // PC wraps modulo the memory depth while PC_4 keeps counting
    setup_img(0);
    w31 = add_i(20, 21, 22);
    w0  = add_i(23, 24, 25);
    img[DEPTH-1] = w31;
    img[0]       = w0;
    reset_load();
    for (int n = 0; n < DEPTH; n++) step(1'b1, 1'b0, 0);
    chk_out("wrap_last", 1'b1, 32'(4 * DEPTH), w31, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    chk_out("wrap_first", 1'b1, 32'(4 * DEPTH + 4), w0, 1'b0, 0);

    // Long stall saturates the counter, then reset mid-stall clears everything
    setup_img(2);
    reset_load();
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b0, 0);
      if (k == 14) chk("sat_cnt14", 32'(bus.stall_count), 32'd14);
    end
    chk_out("sat_cnt", 1'b1, 32'd8, b1, 1'b1, 15);
    tick(1'b1, 1'b1, 0, b1, 1'b1, 1'b0, 0, 1'b0, 32'd0);
    chk_out("rst_mid_stall", 1'b0, 32'd0, 32'd0, 1'b0, 0);
    // reader of r1 must not stall; a same-cycle write to word 0 is not yet visible
    tick(1'b0, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0, 1'b0, 32'd0);
    chk_out("post_rst", 1'b1, 32'd4, b1, 1'b0, 0);

    // Randomized traffic against the reference model
    for (int i = 0; i < DEPTH; i++) img[i] = gen_instr();
    reset_load();
    for (int n = 0; n < 3000; n++) begin
      r   = ($urandom_range(0, 299) == 0);
      we  = ($urandom_range(0, 9) == 0);
      wa  = $urandom_range(0, DEPTH - 1);
      wd  = gen_instr();
      idr = ($urandom_range(0, 3) != 0);
      wbv = ($urandom_range(0, 9) < 4);
      wbr = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, 31);
      rv  = ($urandom_range(0, 24) == 0);
      rpc = $urandom;
      tick(r, we, wa, wd, idr, wbv, wbr, rv, rpc);
      chk_model("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
